// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, coefficient type and base-multiplier state encoding
package kyber_pkg;
    localparam int KYBER_Q    = 3329;
    localparam int KYBER_QINV = -3327;
    typedef logic signed [15:0] coeff_t;
    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, MUL4, DONE} bm_state_t;
endpackage

// File: rtl/montgomery_reduce.sv
// montgomery_reduce: combinational a * 2^-16 mod Q for a 32-bit signed input, result in (-Q, Q)
module montgomery_reduce
    import kyber_pkg::*;
#(
    parameter int Q    = KYBER_Q,
    parameter int QINV = KYBER_QINV
) (
    input  logic signed [31:0] a,
    output coeff_t             r
);
    coeff_t             t;
    logic signed [31:0] u;
    // Only the low half of a*QINV matters, so a 16x16 truncating multiply suffices
    assign t = coeff_t'(a[15:0] * 16'(QINV));
    assign u = a - 32'(t) * Q;
    assign r = u[31:16];
endmodule

// File: rtl/basemul_unit.sv
// basemul_unit: sequential Kyber base-case multiply r = a*b mod (X^2 - zeta)
// sharing one 16x16 multiplier and one Montgomery reducer over five cycles
module basemul_unit
    import kyber_pkg::*;
#(
    parameter int DW = 16,
    parameter int Q  = KYBER_Q
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a0,
    input  logic signed [DW-1:0] a1,
    input  logic signed [DW-1:0] b0,
    input  logic signed [DW-1:0] b1,
    input  logic signed [DW-1:0] zeta,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] r0,
    output logic signed [DW-1:0] r1
);
    bm_state_t state;
    coeff_t a0_q, a1_q, b0_q, b1_q, zeta_q, ma, mb, red;
    logic signed [31:0] prod;

    always_comb begin
        ma = (state == MUL0 || state == MUL4) ? a1_q : (state == MUL1) ? r0 : a0_q;
        mb = (state == MUL0 || state == MUL3) ? b1_q : (state == MUL1) ? zeta_q : b0_q;
    end

    // Full 32-bit product: no truncation before reduction
    assign prod = 32'(ma) * 32'(mb);

    montgomery_reduce #(.Q(Q), .QINV(KYBER_QINV)) u_red (.a(prod), .r(red));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            r0        <= '0;
            r1        <= '0;
            a0_q      <= '0;
            a1_q      <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            zeta_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= !(in_ready && in_valid);
                    if (in_ready && in_valid) begin
                        a0_q   <= a0;
                        a1_q   <= a1;
                        b0_q   <= b0;
                        b1_q   <= b1;
                        zeta_q <= zeta;
                        state  <= MUL0;
                    end
                end
                MUL0: begin r0 <= red;      state <= MUL1; end
                MUL1: begin r0 <= red;      state <= MUL2; end
                MUL2: begin r0 <= r0 + red; state <= MUL3; end
                MUL3: begin r1 <= red;      state <= MUL4; end
                MUL4: begin
                    r1        <= r1 + red;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_basemul_unit.sv
// tb_basemul_unit: scoreboard bench for basemul_unit against an integer reference model
module tb_basemul_unit;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0, zeta = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] r0, r1;

    typedef struct {int r0; int r1;} res_t;
    res_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   rand_or = 1'b0;

    basemul_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .zeta(zeta),
        .out_valid(out_valid), .out_ready(out_ready), .r0(r0), .r1(r1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mont(input int x);
        shortint t;
        t = shortint'(x * -3327);
        return (x - int'(t) * 3329) >>> 16;
    endfunction

    function automatic int fq(input int x, input int y);
        return mont(x * y);
    endfunction

    function automatic res_t model(input int xa0, xa1, xb0, xb1, z);
        res_t m;
        m.r0 = fq(fq(xa1, xb1), z) + fq(xa0, xb0);
        m.r1 = fq(xa0, xb1) + fq(xa1, xb0);
        return m;
    endfunction

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) chk("sb_unexpected_output", 1, 0);
            else begin
                res_t e;
                e = q.pop_front();
                chk("sb_r0", int'(r0), e.r0);
                chk("sb_r1", int'(r1), e.r1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_or) out_ready = $urandom_range(0, 2) != 0;
    endtask

    task automatic send(input int xa0, xa1, xb0, xb1, z);
        int n = 0;
        a0 = 16'(xa0); a1 = 16'(xa1); b0 = 16'(xb0); b1 = 16'(xb1); zeta = 16'(z);
        in_valid = 1'b1;
        q.push_back(model(xa0, xa1, xb0, xb1, z));
        while (!in_ready && n < 200) begin tick(); n++; end
        if (n >= 200) chk("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 300) begin tick(); n++; end
        if (n >= 300) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        res_t e;
        int n;
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_r0", int'(r0), 0);
        chk("rst_r1", int'(r1), 0);
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;

        // direct term and exact latency
        send(1, 0, 1, 0, 0);
        repeat (4) tick();
        chk("lat_early_valid", int'(out_valid), 0);
        tick();
        chk("lat_valid", int'(out_valid), 1);
        chk("t1_r0", int'(r0), 169);
        chk("t1_r1", int'(r1), 0);
        tick();
        chk("t1_in_ready", int'(in_ready), 1);
        chk("t1_valid_drop", int'(out_valid), 0);
        wait_done();

        send(0, 1, 0, 1, 1);
        wait_done();
        send(1, 0, 0, 1, 17);
        wait_done();
        send(0, 0, 0, 0, 0);
        wait_done();
        send(-3328, 3328, -1234, 2999, -1700);
        wait_done();

        // back-pressure with an ignored in_valid pulse during MUL2
        out_ready = 1'b0;
        e = model(5, 7, 11, 13, 17);
        send(5, 7, 11, 13, 17);
        repeat (2) tick();
        a0 = 100; a1 = -200; b0 = 300; b1 = -400; zeta = 999;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk("bp_reach_valid", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_r0", int'(r0), e.r0);
            chk("bp_r1", int'(r1), e.r1);
        end
        out_ready = 1'b1;
        wait_done();
        chk("bp_idle_valid", int'(out_valid), 0);

        // reset while in MUL3
        send(1, 0, 1, 0, 0);
        repeat (3) tick();
        chk("pre_rst_r0", int'(r0), 169);
        reset = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_r0", int'(r0), 0);
        chk("mid_rst_r1", int'(r1), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        tick();
        chk("mid_rst_hold_in_ready", int'(in_ready), 0);
        reset = 1'b1;
        tick();
        send(1, 0, 1, 0, 0);
        wait_done();

        // random regression with random gaps and back-pressure
        rand_or = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(int'($urandom_range(0, 6656)) - 3328, int'($urandom_range(0, 6656)) - 3328,
                 int'($urandom_range(0, 6656)) - 3328, int'($urandom_range(0, 6656)) - 3328,
                 int'($urandom_range(0, 6656)) - 3328);
        end
        rand_or = 1'b0;
        out_ready = 1'b1;
        wait_done();
        chk("final_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
